seven_segment_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver that sits directly downstream of the digit blinker. It takes the packed BCD word the blinker produces and scans one digit at a time onto the board's shared cathode bus. Each digit is decoded to active-low segments, including the blank code 4'b1110 the blinker inserts. The word is snapshotted once per frame so a digit never tears mid-scan.

---
 rtl/seven_segment_scan_driver.sv | 130 +++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Scans one BCD digit per slot onto a shared active-low cathode bus, with an
// anode-off guard window at the start of every slot and a once-per-frame
// snapshot of the digit word so a digit never changes mid-frame.
module seven_segment_scan_driver #(
    parameter int unsigned DECIMAL_DIGITS = 4,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned GUARD_CYCLES   = 1000
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_Enable,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD_Num,
    input  logic [DECIMAL_DIGITS-1:0]   i_DP,
    output logic [DECIMAL_DIGITS-1:0]   o_Anode,
    output logic [6:0]                  o_Segment,
    output logic                        o_DP,
    output logic                        o_Frame_Start
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(DECIMAL_DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DECIMAL_DIGITS - 1);

    localparam logic [3:0] BLANK_CODE = 4'b1110;

    logic [CW-1:0]               r_Cnt;
    logic [IW-1:0]               r_Idx;
    logic [DECIMAL_DIGITS*4-1:0] r_Frame_Bcd;
    logic [DECIMAL_DIGITS-1:0]   r_Frame_Dp;
    logic                        r_Load_Pending;

    logic [DECIMAL_DIGITS-1:0]   r_Anode;
    logic [6:0]                  r_Segment;
    logic                        r_DP;
    logic                        r_Frame_Start;

    logic                        w_Slot_End;
    logic                        w_Frame_End;
    logic                        w_Load;
    logic                        w_Dark;
    logic [3:0]                  w_Digit;
    logic [6:0]                  w_Seg;
    logic [DECIMAL_DIGITS-1:0]   w_Anode_Sel;

    assign w_Slot_End  = (r_Cnt == CNT_LAST);
    assign w_Frame_End = w_Slot_End && (r_Idx == IDX_LAST);
    assign w_Load      = r_Load_Pending || w_Frame_End;
    assign w_Dark      = !i_Enable || (r_Cnt < GUARD_END);
    assign w_Digit     = r_Frame_Bcd[{r_Idx, 2'b00} +: 4];

    // Decode the current digit to active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_Seg = 7'h3F;
        case (w_Digit)
            4'd0:       w_Seg = 7'h40;
            4'd1:       w_Seg = 7'h79;
            4'd2:       w_Seg = 7'h24;
            4'd3:       w_Seg = 7'h30;
            4'd4:       w_Seg = 7'h19;
            4'd5:       w_Seg = 7'h12;
            4'd6:       w_Seg = 7'h02;
            4'd7:       w_Seg = 7'h78;
            4'd8:       w_Seg = 7'h00;
            4'd9:       w_Seg = 7'h10;
            BLANK_CODE: w_Seg = 7'h7F;
            default:    w_Seg = 7'h3F;
        endcase
    end

    // One-cold anode select for the current slot
    always_comb begin
        w_Anode_Sel        = '1;
        w_Anode_Sel[r_Idx] = 1'b0;
    end

    // Slot counter and digit index; free-running regardless of enable
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Cnt <= '0;
            r_Idx <= '0;
        end else begin
            if (w_Slot_End) begin
                r_Cnt <= '0;
                r_Idx <= (r_Idx == IDX_LAST) ? '0 : r_Idx + 1'b1;
            end else begin
                r_Cnt <= r_Cnt + 1'b1;
            end
        end
    end

    // Frame snapshot: once after reset, then at the last cycle of each frame
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Frame_Bcd    <= {DECIMAL_DIGITS{BLANK_CODE}};
            r_Frame_Dp     <= '0;
            r_Load_Pending <= 1'b1;
        end else begin
            r_Load_Pending <= 1'b0;
            if (w_Load) begin
                r_Frame_Bcd <= i_BCD_Num;
                r_Frame_Dp  <= i_DP;
            end
        end
    end

    // Registered outputs, one cycle behind the scan state
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Anode       <= '1;
            r_Segment     <= 7'h7F;
            r_DP          <= 1'b1;
            r_Frame_Start <= 1'b0;
        end else begin
            r_Anode       <= w_Dark ? '1 : w_Anode_Sel;
            r_Segment     <= w_Seg;
            r_DP          <= w_Dark ? 1'b1 : ~r_Frame_Dp[r_Idx];
            r_Frame_Start <= w_Load;
        end
    end

    assign o_Anode       = r_Anode;
    assign o_Segment     = r_Segment;
    assign o_DP          = r_DP;
    assign o_Frame_Start = r_Frame_Start;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: a cycle-count reference model pushes
// the expected outputs for each edge into a queue, which is popped and
// compared once the DUT has registered that edge.
module tb_seven_segment_scan_driver;

    localparam int D = 4;
    localparam int R = 8;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [15:0]  bcd;
    logic [3:0]   dp;
    logic [3:0]   anode;
    logic [6:0]   seg;
    logic         dp_n;
    logic         fs;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;

    int          m_t;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;

    seven_segment_scan_driver #(
        .DECIMAL_DIGITS (D),
        .REFRESH_DIV    (R),
        .GUARD_CYCLES   (G)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Enable      (en),
        .i_BCD_Num     (bcd),
        .i_DP          (dp),
        .o_Anode       (anode),
        .o_Segment     (seg),
        .o_DP          (dp_n),
        .o_Frame_Start (fs)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hE: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
        end
    endtask

    // Predict outputs for the coming edge, advance the model, clock, compare
    task automatic step();
        exp_t       e;
        int         slot;
        int         ph;
        logic [3:0] d;
        if (rst) begin
            e     = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
            m_t   = 0;
            m_bcd = 16'hEEEE;
            m_dp  = 4'h0;
        end else begin
            slot  = (m_t / R) % D;
            ph    = m_t % R;
            d     = m_bcd[slot*4 +: 4];
            e.seg = seg_of(d);
            if (!en || ph < G) begin
                e.an = 4'hF;
                e.dp = 1'b1;
            end else begin
                e.an = ~(4'b0001 << slot);
                e.dp = ~m_dp[slot];
            end
            e.fs = (m_t == 0) || (ph == R - 1 && slot == D - 1);
            if (e.fs) begin
                m_bcd = bcd;
                m_dp  = dp;
            end
            m_t++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("anode", {12'h0, anode}, {12'h0, e.an});
        chk("segment", {9'h0, seg}, {9'h0, e.seg});
        chk("dp", {15'h0, dp_n}, {15'h0, e.dp});
        chk("frame_start", {15'h0, fs}, {15'h0, e.fs});
    endtask

    task automatic run_to(input int c);
        while (m_t < c) step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        bcd = 16'h1234;
        dp  = 4'h0;
        m_t = 0;
        @(negedge clk);

        // Reset held three cycles
        repeat (3) step();
        chk("rst_anode", {12'h0, anode}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_fs", {15'h0, fs}, 16'h0000);
        rst = 1'b0;

        // Scan and decode of 1234
        run_to(1);
        chk("fs_first", {15'h0, fs}, 16'h0001);
        run_to(5);
        chk("slot0_an", {12'h0, anode}, 16'h000E);
        chk("slot0_seg", {9'h0, seg}, 16'h0019);
        run_to(13);
        chk("slot1_an", {12'h0, anode}, 16'h000D);
        chk("slot1_seg", {9'h0, seg}, 16'h0030);
        run_to(21);
        chk("slot2_an", {12'h0, anode}, 16'h000B);
        chk("slot2_seg", {9'h0, seg}, 16'h0024);
        run_to(29);
        chk("slot3_an", {12'h0, anode}, 16'h0007);
        chk("slot3_seg", {9'h0, seg}, 16'h0079);
        run_to(32);
        chk("fs_second", {15'h0, fs}, 16'h0001);
        run_to(37);
        chk("repeat_seg", {9'h0, seg}, 16'h0019);
        run_to(70);

        // Blank and invalid codes
        rst = 1'b1;
        bcd = 16'h1E5A;
        step();
        rst = 1'b0;
        run_to(5);
        chk("invalid_seg", {9'h0, seg}, 16'h003F);
        run_to(13);
        chk("five_seg", {9'h0, seg}, 16'h0012);
        run_to(21);
        chk("blank_an", {12'h0, anode}, 16'h000B);
        chk("blank_seg", {9'h0, seg}, 16'h007F);
        run_to(40);

        // Snapshot isolation
        rst = 1'b1;
        bcd = 16'h0000;
        step();
        rst = 1'b0;
        run_to(12);
        bcd = 16'h8888;
        run_to(30);
        chk("iso_slot3", {9'h0, seg}, 16'h0040);
        run_to(32);
        chk("iso_fs", {15'h0, fs}, 16'h0001);
        chk("iso_last", {9'h0, seg}, 16'h0040);
        run_to(37);
        chk("iso_new", {9'h0, seg}, 16'h0000);

        // Enable gating and decimal point
        rst = 1'b1;
        bcd = 16'h1234;
        dp  = 4'b0100;
        step();
        rst = 1'b0;
        run_to(10);
        en = 1'b0;
        run_to(21);
        chk("en_off_an", {12'h0, anode}, 16'h000F);
        chk("en_off_dp", {15'h0, dp_n}, 16'h0001);
        en = 1'b1;
        run_to(23);
        chk("dp_on_an", {12'h0, anode}, 16'h000B);
        chk("dp_on", {15'h0, dp_n}, 16'h0000);
        run_to(27);
        chk("dp_off_slot3", {15'h0, dp_n}, 16'h0001);

        // Reset mid-scan
        run_to(45);
        rst = 1'b1;
        step();
        chk("mid_rst_an", {12'h0, anode}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
        rst = 1'b0;
        step();
        chk("mid_rst_fs", {15'h0, fs}, 16'h0001);
        run_to(5);
        chk("mid_rst_slot0", {12'h0, anode}, 16'h000E);
        run_to(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
